// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit between the core memory port and a req/rsp bus.
// Optional bus timeout abort is enabled by defining LSU_TIMEOUT_EN.
module riscv_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_wen,
    input  logic [2:0]  req_memop,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        fault,
    output logic        err,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_req_addr,
    output logic        bus_req_wen,
    output logic [3:0]  bus_req_wstrb,
    output logic [31:0] bus_req_wdata,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e      state_q, state_d;
    logic [1:0]  a_q, a_d;
    logic [2:0]  op_q, op_d;
    logic        wen_q, wen_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  strb_q, strb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        illegal;
    logic        misalign;
    logic        accept;
    logic [3:0]  strb_base;
    logic [31:0] wrep;
    logic [31:0] shifted;
    logic [31:0] ld_data;

`ifdef LSU_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          tmo;
    assign tmo = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Decode illegal memops and misaligned addresses of the incoming request.
    always_comb begin
        illegal  = 1'b0;
        misalign = 1'b0;
        if (req_wen) begin
            illegal = req_memop[2] | (req_memop[1:0] == 2'b11);
        end else begin
            illegal = (req_memop[1:0] == 2'b11) | (req_memop[2] & req_memop[1]);
        end
        unique case (req_memop[1:0])
            2'b01:   misalign = req_addr[0];
            2'b10:   misalign = (req_addr[1:0] != 2'b00);
            default: misalign = 1'b0;
        endcase
    end

    assign fault  = (state_q == IDLE) & req_valid & (illegal | misalign);
    assign accept = (state_q == IDLE) & req_valid & ~(illegal | misalign);
    assign stall  = accept | (state_q == REQ) | (state_q == WAIT);

    assign rsp_valid     = (state_q == DONE);
    assign rsp_rdata     = rdata_q;
    assign bus_req_valid = (state_q == REQ);
    assign bus_req_addr  = addr_q;
    assign bus_req_wen   = wen_q;
    assign bus_req_wstrb = strb_q;
    assign bus_req_wdata = wdata_q;

    // Replicate store data into every lane and pick the base strobe pattern.
    always_comb begin
        wrep      = req_wdata;
        strb_base = 4'b1111;
        unique case (req_memop[1:0])
            2'b00: begin
                wrep      = {4{req_wdata[7:0]}};
                strb_base = 4'b0001;
            end
            2'b01: begin
                wrep      = {2{req_wdata[15:0]}};
                strb_base = 4'b0011;
            end
            default: begin
                wrep      = req_wdata;
                strb_base = 4'b1111;
            end
        endcase
    end

    // Align the returned word and apply sign or zero extension.
    always_comb begin
        shifted = bus_rsp_rdata >> {a_q, 3'b000};
        unique case (op_q)
            3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ld_data = {24'h0, shifted[7:0]};
            3'b101:  ld_data = {16'h0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

    // Next-state logic for the access sequencer.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        op_d    = op_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        strb_d  = strb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = req_addr[1:0];
                    op_d    = req_memop;
                    wen_d   = req_wen;
                    addr_d  = {req_addr[31:2], 2'b00};
                    strb_d  = req_wen ? (strb_base << req_addr[1:0]) : 4'b0000;
                    wdata_d = wrep;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus_req_ready) begin
                    state_d = WAIT;
`ifdef LSU_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            WAIT: begin
                if (bus_rsp_valid) begin
                    rdata_d = wen_q ? 32'h0 : ld_data;
                    state_d = DONE;
                end
`ifdef LSU_TIMEOUT_EN
                else if (tmo) begin
                    rdata_d = 32'hDEADBEEF;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= 2'b00;
            op_q    <= 3'b000;
            wen_q   <= 1'b0;
            addr_q  <= 32'h0;
            strb_q  <= 4'b0000;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            op_q    <= op_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            strb_q  <= strb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: scoreboard bench with a reactive bus model and a reference model.
// Timeout scenario is exercised when LSU_TIMEOUT_EN is defined.
module tb_riscv_lsu;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_wen;
    logic [2:0]  req_memop;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        fault;
    logic        err;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_req_addr;
    logic        bus_req_wen;
    logic [3:0]  bus_req_wstrb;
    logic [31:0] bus_req_wdata;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;

    riscv_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_wen(req_wen), .req_memop(req_memop),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .fault(fault), .err(err),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_req_addr(bus_req_addr), .bus_req_wen(bus_req_wen),
        .bus_req_wstrb(bus_req_wstrb), .bus_req_wdata(bus_req_wdata),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } rsp_exp_t;

    bus_exp_t bexp_q[$];
    rsp_exp_t rexp_q[$];

    int n_pass = 0;
    int n_total = 0;

    int          g_rdy_dly = 0;
    int          g_rsp_dly = 0;
    logic [31:0] g_word = 32'h0;
    logic        g_silent = 1'b0;
    logic        g_early = 1'b0;
    logic        g_force = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int m_size(input int op);
        int k;
        k = op % 4;
        if (k == 0) return 1;
        if (k == 1) return 2;
        return 4;
    endfunction

    function automatic bit m_legal(input bit wen, input int op, input int a);
        if (wen && op > 2) return 1'b0;
        if (!wen && (op == 3 || op == 6 || op == 7)) return 1'b0;
        return (a % m_size(op)) == 0;
    endfunction

    function automatic logic [3:0] m_strb(input bit wen, input int op, input int a);
        int n;
        if (!wen) return 4'b0000;
        n = m_size(op);
        return 4'(((1 << n) - 1) << a);
    endfunction

    function automatic logic [31:0] m_wdata(input int op, input logic [31:0] d);
        int n;
        n = m_size(op);
        if (n == 1) return (d % 256) * 32'h01010101;
        if (n == 2) return (d % 65536) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input int op, input int a, input logic [31:0] word);
        logic [31:0] v;
        logic [31:0] b;
        v = word >> (8 * a);
        case (op)
            0: begin
                b = v % 256;
                return (b >= 128) ? b + 32'hFFFFFF00 : b;
            end
            1: begin
                b = v % 65536;
                return (b >= 32768) ? b + 32'hFFFF0000 : b;
            end
            4: return v % 256;
            5: return v % 65536;
            default: return word;
        endcase
    endfunction

    // Bus slave model: checks each request and answers with programmed delays.
    initial begin
        int       bm;
        int       bm_cnt;
        bus_exp_t e;
        bus_exp_t cap;
        bm = 0;
        bm_cnt = 0;
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0;
        bus_rsp_rdata = 32'h0;
        forever begin
            @(negedge clk);
            bus_rsp_valid = g_force;
            bus_rsp_rdata = $urandom;
            if (rst) begin
                bm = 0;
                bus_req_ready = 1'b0;
            end else begin
                case (bm)
                    0: if (bus_req_valid) begin
                        cap.addr  = bus_req_addr;
                        cap.wen   = bus_req_wen;
                        cap.strb  = bus_req_wstrb;
                        cap.wdata = bus_req_wdata;
                        if (bexp_q.size() == 0) begin
                            chk("bus_unexpected_req", 32'd1, 32'd0);
                        end else begin
                            e = bexp_q.pop_front();
                            chk("bus_addr", cap.addr, e.addr);
                            chk("bus_wen", {31'h0, cap.wen}, {31'h0, e.wen});
                            chk("bus_wstrb", {28'h0, cap.strb}, {28'h0, e.strb});
                            if (e.wen) chk("bus_wdata", cap.wdata, e.wdata);
                        end
                        bm_cnt = g_rdy_dly;
                        bus_req_ready = (bm_cnt == 0);
                        if (bus_req_ready && g_early) bus_rsp_valid = 1'b1;
                        bm = 1;
                    end
                    1: if (bus_req_ready) begin
                        bus_req_ready = 1'b0;
                        chk("bus_req_dropped", {31'h0, bus_req_valid}, 32'd0);
                        bm_cnt = g_rsp_dly;
                        bm = 2;
                        if (bm_cnt == 0 && !g_silent) begin
                            bus_rsp_valid = 1'b1;
                            bus_rsp_rdata = g_word;
                            bm = 0;
                        end
                    end else begin
                        chk("hold_ctrl", {26'h0, bus_req_valid, bus_req_wen, bus_req_wstrb},
                            {26'h0, 1'b1, cap.wen, cap.strb});
                        chk("hold_addr", bus_req_addr, cap.addr);
                        chk("hold_wdata", bus_req_wdata, cap.wdata);
                        bm_cnt--;
                        bus_req_ready = (bm_cnt == 0);
                        if (bus_req_ready && g_early) bus_rsp_valid = 1'b1;
                    end
                    default: if (!g_silent) begin
                        bm_cnt--;
                        if (bm_cnt <= 0) begin
                            bus_rsp_valid = 1'b1;
                            bus_rsp_rdata = g_word;
                            bm = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Response monitor: pops the scoreboard whenever the DUT completes an access.
    initial begin
        rsp_exp_t re;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                if (rexp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    re = rexp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, re.rd);
                    chk("rsp_err", {31'h0, err}, {31'h0, re.err});
                end
            end
        end
    end

    task automatic do_reset();
        req_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rexp_q.delete();
        bexp_q.delete();
        #1 rst = 1'b0;
    endtask

    task automatic do_req(input logic wen, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] d, input logic [31:0] word,
                          input int rdy, input int rsp, input logic early, input logic silent,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_stall);
        bus_exp_t be;
        rsp_exp_t re;
        int       sc;
        bit       done;
        be.addr  = addr - (addr % 4);
        be.wen   = wen;
        be.strb  = m_strb(wen, int'(op), int'(addr % 4));
        be.wdata = m_wdata(int'(op), d);
        bexp_q.push_back(be);
        re.rd  = exp_rd;
        re.err = exp_err;
        rexp_q.push_back(re);
        g_rdy_dly = rdy;
        g_rsp_dly = rsp;
        g_word    = word;
        g_early   = early;
        g_silent  = silent;
        req_valid = 1'b1;
        req_wen   = wen;
        req_memop = op;
        req_addr  = addr;
        req_wdata = d;
        #1;
        chk("fault_on_legal", {31'h0, fault}, 32'd0);
        chk("stall_on_accept", {31'h0, stall}, 32'd1);
        sc = 1;
        done = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                done = 1'b1;
                break;
            end
            if (stall) sc++;
        end
        chk("access_completes", {31'h0, done}, 32'd1);
        if (!done) begin
            do_reset();
        end else begin
            if (exp_stall >= 0) chk("stall_cycles", sc, exp_stall);
            @(negedge clk);
            chk("rsp_single_pulse", {31'h0, rsp_valid}, 32'd0);
            chk("no_reissue", {31'h0, bus_req_valid}, 32'd0);
            req_valid = 1'b0;
        end
        g_silent = 1'b0;
        g_early  = 1'b0;
    endtask

    task automatic do_fault(input logic wen, input logic [2:0] op, input logic [31:0] addr, input int cyc);
        req_valid = 1'b1;
        req_wen   = wen;
        req_memop = op;
        req_addr  = addr;
        req_wdata = $urandom;
        #1;
        chk("fault_flag", {31'h0, fault}, 32'd1);
        chk("fault_no_stall", {31'h0, stall}, 32'd0);
        repeat (cyc) begin
            @(negedge clk);
            chk("fault_no_bus", {31'h0, bus_req_valid}, 32'd0);
        end
        req_valid = 1'b0;
    endtask

    initial begin
        int          op;
        int          a;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] d;
        logic [31:0] word;
        int          cnt;
        bus_exp_t    be;

        rst = 1'b1;
        req_valid = 1'b0;
        req_wen = 1'b0;
        req_memop = 3'b000;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_stall", {31'h0, stall}, 32'd0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_fault_err", {30'h0, fault, err}, 32'd0);
        chk("rst_bus_valid", {31'h0, bus_req_valid}, 32'd0);
        chk("rst_bus_addr", bus_req_addr, 32'h0);
        chk("rst_bus_wstrb", {28'h0, bus_req_wstrb}, 32'h0);
        chk("rst_bus_wdata", bus_req_wdata, 32'h0);
        #1 rst = 1'b0;
        @(negedge clk);

        do_req(1'b0, 3'b010, 32'h80000008, 32'h0, 32'h11223344, 0, 0, 1'b0, 1'b0, 32'h11223344, 1'b0, 3);
        do_req(1'b0, 3'b000, 32'h80000003, 32'h0, 32'h80FFFFFF, 0, 0, 1'b0, 1'b0, 32'hFFFFFF80, 1'b0, 3);
        do_req(1'b0, 3'b100, 32'h80000003, 32'h0, 32'h80FFFFFF, 0, 0, 1'b0, 1'b0, 32'h00000080, 1'b0, 3);
        do_req(1'b0, 3'b101, 32'h80000002, 32'h0, 32'hBEEF0000, 0, 0, 1'b0, 1'b0, 32'h0000BEEF, 1'b0, 3);
        do_req(1'b1, 3'b000, 32'h80000001, 32'h000000A5, 32'h12345678, 0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 3);
        do_req(1'b1, 3'b001, 32'h80000002, 32'h1234ABCD, 32'hCAFEF00D, 0, 1, 1'b0, 1'b0, 32'h0, 1'b0, 4);
        do_req(1'b0, 3'b001, 32'h80000002, 32'h0, 32'h80011234, 3, 2, 1'b1, 1'b0, 32'hFFFF8001, 1'b0, 8);

        do_fault(1'b0, 3'b010, 32'h80000002, 5);
        do_fault(1'b0, 3'b011, 32'h80000000, 5);
        do_fault(1'b1, 3'b100, 32'h80000000, 1);
        do_fault(1'b0, 3'b101, 32'h80000001, 1);

        for (int i = 0; i < 80; i++) begin
            op   = int'($urandom_range(0, 7));
            a    = int'($urandom_range(0, 3));
            wen  = 1'($urandom_range(0, 1));
            addr = 32'h80000000 | ($urandom & 32'h00000FFC) | 32'(a);
            d    = $urandom;
            word = $urandom;
            if (m_legal(wen, op, a)) begin
                do_req(wen, 3'(op), addr, d, word,
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       ($urandom_range(0, 3) == 0), 1'b0,
                       wen ? 32'h0 : m_load(op, a, word), 1'b0, -1);
            end else begin
                do_fault(wen, 3'(op), addr, 1);
            end
            repeat ($urandom_range(0, 2)) begin
                req_addr = $urandom;
                @(negedge clk);
            end
        end

`ifdef LSU_TIMEOUT_EN
        do_req(1'b0, 3'b010, 32'h80000010, 32'h0, 32'h0, 0, 0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 6);
        do_reset();
`else
        be.addr = 32'h80000010;
        be.wen = 1'b0;
        be.strb = 4'b0000;
        be.wdata = 32'h0;
        bexp_q.push_back(be);
        g_rdy_dly = 0;
        g_silent = 1'b1;
        req_valid = 1'b1;
        req_wen = 1'b0;
        req_memop = 3'b010;
        req_addr = 32'h80000010;
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (stall) cnt++;
        end
        chk("stall_held_no_rsp", cnt, 100);
        do_reset();
        g_silent = 1'b0;
`endif
        @(negedge clk);

        be.addr = 32'h80000020;
        be.wen = 1'b0;
        be.strb = 4'b0000;
        be.wdata = 32'h0;
        bexp_q.push_back(be);
        g_rdy_dly = 0;
        g_silent = 1'b1;
        req_valid = 1'b1;
        req_wen = 1'b0;
        req_memop = 3'b010;
        req_addr = 32'h80000020;
        repeat (2) @(negedge clk);
        chk("in_wait_stall", {31'h0, stall}, 32'd1);
        chk("in_wait_no_req", {31'h0, bus_req_valid}, 32'd0);
        rst = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_wait_stall", {31'h0, stall}, 32'd0);
        chk("rst_wait_idle", {30'h0, rsp_valid, bus_req_valid}, 32'd0);
        #1 rst = 1'b0;
        g_force = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 2) g_force = 1'b0;
            chk("rsp_after_rst", {31'h0, rsp_valid}, 32'd0);
        end
        g_silent = 1'b0;

        do_req(1'b0, 3'b000, 32'h80000005, 32'h0, 32'h00007F00, 1, 0, 1'b0, 1'b0, 32'h0000007F, 1'b0, 4);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", rexp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
